// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN layer sequencer: element/vector sizes,
// sequencer state encoding and packed-vector element access.
package dnn_pkg;

  localparam int DATA_W = 16;
  localparam int VEC_N  = 8;
  localparam int VEC_W  = DATA_W * VEC_N;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_CAPT,
    S_ARG,
    S_DONE
  } state_e;

  function automatic logic signed [DATA_W-1:0] vec_get(input logic [VEC_W-1:0] v, input int i);
    return v[DATA_W*i +: DATA_W];
  endfunction

  function automatic logic [VEC_W-1:0] vec_set(input logic [VEC_W-1:0] v, input int i,
                                               input logic [DATA_W-1:0] e);
    logic [VEC_W-1:0] r;
    r = v;
    r[DATA_W*i +: DATA_W] = e;
    return r;
  endfunction

endpackage

// File: rtl/dnn_seq_argmax8.sv
// argmax8: combinational signed 8-way compare tree; ties go to the lower index.
module argmax8
  import dnn_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [2:0]       idx_o
);

  logic signed [DATA_W-1:0] v1 [4];
  logic        [2:0]        i1 [4];
  logic signed [DATA_W-1:0] v2 [2];
  logic        [2:0]        i2 [2];

  // The left operand always carries the lower index, so >= keeps ties low.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (vec_get(vec_i, 2*k) >= vec_get(vec_i, 2*k+1)) begin
        v1[k] = vec_get(vec_i, 2*k);
        i1[k] = 3'(2*k);
      end else begin
        v1[k] = vec_get(vec_i, 2*k+1);
        i1[k] = 3'(2*k+1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (v1[2*k] >= v1[2*k+1]) begin
        v2[k] = v1[2*k];
        i2[k] = i1[2*k];
      end else begin
        v2[k] = v1[2*k+1];
        i2[k] = i1[2*k+1];
      end
    end
    idx_o = (v2[0] >= v2[1]) ? i2[0] : i2[1];
  end

endmodule

// File: rtl/dnn_seq.sv
// dnn_seq: runs NUM_LAYERS dense+sigmoid layers on one shared datapath, owning the
// activation buffer. Optional argmax output under macro DNN_SEQ_ARGMAX_EN.
module dnn_seq
  import dnn_pkg::*;
#(
  parameter  int NUM_LAYERS = 3,
  parameter  int DP_LATENCY = 2,
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [VEC_W-1:0] in_vec,
  input  logic [VEC_W-1:0] dp_a,
  output logic [VEC_W-1:0] dp_x,
  output logic             dp_en,
  output logic             dp_clr,
  output logic [LW-1:0]    layer_sel,
  output logic             busy,
  output logic             done,
  output logic [VEC_W-1:0] out_vec,
  output logic [2:0]       out_class
);

  localparam int CW = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;

`ifdef DNN_SEQ_ARGMAX_EN
  localparam state_e LAST_NEXT = S_ARG;
`else
  localparam state_e LAST_NEXT = S_DONE;
`endif

  state_e           state_q, state_d;
  logic [VEC_W-1:0] buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    layer_q, layer_d;
  logic [VEC_W-1:0] out_vec_q;
  logic             done_q;
  logic             abort_clr_q;

  // states: IDLE wait | CLR clear dp | RUN dp_en | CAPT latch dp_a | ARG argmax | DONE pulse
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    dp_en   = 1'b0;
    dp_clr  = abort_clr_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          buf_d   = in_vec;
          layer_d = '0;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        dp_clr  = 1'b1;
        cnt_d   = CW'(DP_LATENCY - 1);
        state_d = S_RUN;
      end
      S_RUN: begin
        dp_en = 1'b1;
        if (cnt_q == '0) state_d = S_CAPT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPT: begin
        buf_d = dp_a;
        if (layer_q == LW'(NUM_LAYERS - 1)) begin
          state_d = LAST_NEXT;
        end else begin
          layer_d = layer_q + 1'b1;
          state_d = S_CLR;
        end
      end
      S_ARG:  state_d = S_DONE;
      S_DONE: begin
        layer_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      layer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_q       <= '0;
      cnt_q       <= '0;
      layer_q     <= '0;
      out_vec_q   <= '0;
      done_q      <= 1'b0;
      abort_clr_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      layer_q     <= layer_d;
      done_q      <= (state_d == S_DONE);
      abort_clr_q <= abort && (state_q != S_IDLE);
      if (state_d == S_DONE) out_vec_q <= buf_d;
    end
  end

`ifdef DNN_SEQ_ARGMAX_EN
  logic [2:0] arg_idx;
  logic [2:0] class_q;

  argmax8 u_argmax8 (
    .vec_i (buf_q),
    .idx_o (arg_idx)
  );

  always_ff @(posedge clk) begin
    if (rst)                                         class_q <= '0;
    else if (state_q == S_ARG && state_d == S_DONE)  class_q <= arg_idx;
  end

  assign out_class = class_q;
`else
  assign out_class = 3'd0;
`endif

  assign dp_x      = buf_q;
  assign layer_sel = layer_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign out_vec   = out_vec_q;

endmodule

// File: tb/tb_dnn_seq.sv
// Bench for dnn_seq: directed inferences, expected results queued at start and
// checked by a done-driven monitor; control timing, abort and reset checked inline.
module tb_dnn_seq;
  import dnn_pkg::*;

  localparam int NL = 3;
`ifdef DNN_SEQ_ARGMAX_EN
  localparam int LAT    = 14;
  localparam bit ARG_ON = 1'b1;
`else
  localparam int LAT    = 13;
  localparam bit ARG_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, start, abort;
  logic [VEC_W-1:0] in_vec, dp_a, dp_x, out_vec;
  logic             dp_en, dp_clr, busy, done;
  logic [1:0]       layer_sel;
  logic [2:0]       out_class;

  int checks = 0;
  int errors = 0;
  int ecnt   = 0;
  int dp_mode = 0;

  int               exp_e_q [$];
  logic [VEC_W-1:0] exp_v_q [$];
  logic [2:0]       exp_c_q [$];

  dnn_seq #(.NUM_LAYERS(NL), .DP_LATENCY(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .in_vec    (in_vec),
    .dp_a      (dp_a),
    .dp_x      (dp_x),
    .dp_en     (dp_en),
    .dp_clr    (dp_clr),
    .layer_sel (layer_sel),
    .busy      (busy),
    .done      (done),
    .out_vec   (out_vec),
    .out_class (out_class)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  function automatic logic [VEC_W-1:0] mk(input int e0, e1, e2, e3, e4, e5, e6, e7);
    logic [VEC_W-1:0] v;
    int e [8];
    e = '{e0, e1, e2, e3, e4, e5, e6, e7};
    v = '0;
    for (int i = 0; i < 8; i++) v = vec_set(v, i, 16'(e[i]));
    return v;
  endfunction

  logic [VEC_W-1:0] fixed_v;
  initial fixed_v = mk(5, -3, 9, 9, 0, 0, 0, 0);

  // Datapath stand-in: each element +1 per layer; mode 1 forces a fixed last layer.
  always_comb begin
    dp_a = '0;
    for (int i = 0; i < 8; i++) dp_a = vec_set(dp_a, i, 16'(vec_get(dp_x, i) + 16'sd1));
    if (dp_mode == 1 && layer_sel == 2'(NL - 1)) dp_a = fixed_v;
  end

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int               m_e;
  logic [VEC_W-1:0] m_v;
  logic [2:0]       m_c;
  always @(negedge clk) begin
    if (done) begin
      if (exp_e_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done edge=%0d actual=1 required=0", ecnt);
      end else begin
        m_e = exp_e_q.pop_front();
        m_v = exp_v_q.pop_front();
        m_c = exp_c_q.pop_front();
        chk("done_cycle", VEC_W'(ecnt), VEC_W'(m_e));
        chk("out_vec", out_vec, m_v);
        chk("out_class", VEC_W'(out_class), VEC_W'(m_c));
      end
    end
  end

  task automatic push_exp(input int e, input logic [VEC_W-1:0] v, input logic [2:0] c);
    exp_e_q.push_back(e);
    exp_v_q.push_back(v);
    exp_c_q.push_back(ARG_ON ? c : 3'd0);
  endtask

  // Returns after the accepting edge (edge 0), during cycle 1.
  task automatic issue(input logic [VEC_W-1:0] v, input bit push, input logic [VEC_W-1:0] ev,
                       input logic [2:0] ec);
    @(negedge clk);
    in_vec = v;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) push_exp(ecnt + LAT - 1, ev, ec);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_e_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_e_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_e_q.size());
      exp_e_q.delete();
      exp_v_q.delete();
      exp_c_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  logic [VEC_W-1:0] vb_exp;
  logic [4:0]       ctl_exp;
  int               l, ph;

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_vec = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset state
    chk("rst_ctl", VEC_W'({dp_en, dp_clr, busy, done, layer_sel}), '0);
    chk("rst_out_vec", out_vec, '0);
    chk("rst_out_class", VEC_W'(out_class), '0);

    // A: zero input, three +1 layers -> 3; control timing per cycle
    issue(mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, mk(3, 3, 3, 3, 3, 3, 3, 3), 3'd0);
    for (int c = 1; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c <= 4 * NL) begin
        l  = (c - 1) / 4;
        ph = (c - 1) % 4;
        ctl_exp = {ph == 0, ph == 1 || ph == 2, 1'b1, 2'(l)};
      end else if (c <= LAT) begin
        ctl_exp = {1'b0, 1'b0, 1'b1, 2'(NL - 1)};
      end else begin
        ctl_exp = 5'b0;
      end
      chk($sformatf("ctl_c%0d", c), VEC_W'({dp_clr, dp_en, busy, layer_sel}), VEC_W'(ctl_exp));
    end
    drain("A");

    // B: signed/wrap elements
    vb_exp = mk(103, 2, 16'h8001, -197, 503, 3, 4, 5);
    issue(mk(100, -1, 16'h7FFE, -200, 500, 0, 1, 2), 1'b1, vb_exp, 3'd4);
    drain("B");

    // abort in cycle 6
    issue(mk(1, 1, 1, 1, 1, 1, 1, 1), 1'b0, '0, 3'd0);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_c7", VEC_W'({busy, dp_clr, dp_en, done}), VEC_W'(4'b0100));
    @(negedge clk);
    chk("abort_c8", VEC_W'({busy, dp_clr, dp_en, done}), VEC_W'(4'b0000));
    chk("abort_out_vec", out_vec, vb_exp);
    issue(mk(-10, -20, -30, -5, -40, -50, -60, -70), 1'b1,
          mk(-7, -17, -27, -2, -37, -47, -57, -67), 3'd3);
    drain("C");

    // start held: back-to-back, done at 13/27/41
    @(negedge clk);
    in_vec = mk(16, 16, 16, 16, 16, 16, 16, 16);
    start  = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      push_exp(ecnt + k * (LAT + 1) + LAT - 1, mk(19, 19, 19, 19, 19, 19, 19, 19), 3'd0);
    repeat (2 * (LAT + 1)) @(posedge clk);
    #1;
    start = 1'b0;
    drain("held");

    // reset in cycle 8
    issue(mk(2, 2, 2, 2, 2, 2, 2, 2), 1'b0, '0, 3'd0);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ctl", VEC_W'({dp_en, dp_clr, busy, done, layer_sel}), '0);
    chk("midrst_out_vec", out_vec, '0);
    chk("midrst_out_class", VEC_W'(out_class), '0);
    issue(mk(0, 0, 0, 0, 0, 0, 0, 40), 1'b1, mk(3, 3, 3, 3, 3, 3, 3, 43), 3'd7);
    drain("D");

    // fixed final layer {5,-3,9,9,0...}: tie between 2 and 3 resolves to 2
    dp_mode = 1;
    issue(mk(7, 7, 7, 7, 7, 7, 7, 7), 1'b1, mk(5, -3, 9, 9, 0, 0, 0, 0), 3'd2);
    drain("E");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dnn_seq.md
# dnn_seq

Layer sequencer for the 8-neuron DNN datapath: runs an input vector through NUM_LAYERS dense+sigmoid layers on one shared datapath instance. It owns the activation buffer, so layer k's outputs become layer k+1's inputs. It drives the datapath's enable/clear and the weight-bank layer select, and returns the final activation vector with a done pulse. It sits between the AXI/register front end and the datapath plus weight banks.

## Interface
Parameters:
- NUM_LAYERS, 3, number of layers run per inference (1..16)
- DP_LATENCY, 2, cycles of dp_en needed from a clear until dp_a holds that layer's result (≥1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin inference; sampled only in IDLE
- abort  in  1  cancel current inference
- in_vec  in  128  input vector, element i = bits [16i+15:16i], signed Q-format as datapath
- dp_a  in  128  datapath activation outputs a0..a7, same packing
- dp_x  out  128  datapath inputs x0..x7 (= activation buffer)
- dp_en  out  1  datapath enable
- dp_clr  out  1  datapath accumulator/register clear
- layer_sel  out  LW  weight-bank select, LW = max(1, clog2(NUM_LAYERS))
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse, out_vec valid
- out_vec  out  128  final-layer activations, held until next done
- out_class  out  3  argmax index (only with DNN_SEQ_ARGMAX_EN)

## Operation
- States: IDLE, CLR, RUN, CAPT, [ARG], DONE.
- IDLE: when start=1, load in_vec into the activation buffer, set layer_sel=0, and go to CLR. Otherwise stay.
- CLR: dp_clr=1 and dp_en=0 for one cycle. Load run counter with DP_LATENCY-1. Go to RUN.
- RUN: dp_en=1. Decrement counter. At 0, go to CAPT.
- CAPT: dp_en=0. The activation buffer loads dp_a.
  - If layer_sel = NUM_LAYERS-1, go to DONE (ARG if the macro is defined).
  - Else increment layer_sel and go to CLR.
- ARG: register the argmax of the buffer into out_class. Go to DONE.
- DONE: done=1 and out_vec ← buffer (same edge). Go to IDLE. layer_sel returns to 0.
- dp_x is always driven by the buffer, so it is stable for the whole of CLR and RUN.
- start outside IDLE (including the DONE cycle) is ignored and not queued.
- abort in any non-IDLE state:
  - next state IDLE, with dp_clr=1 for that one cycle;
  - no done pulse; out_vec and out_class are unchanged; buffer contents are don't-care.
- abort has priority over every transition. abort in IDLE is ignored. start and abort together in IDLE: start wins.
- Output values during IDLE: dp_en=0, dp_clr=0, busy=0.

## Timing
- Reset (rst=1 at an edge):
  - state IDLE; buffer, out_vec, out_class and layer_sel are 0;
  - dp_en, dp_clr, busy and done are 0.
  - Applies mid-inference with no done pulse.
- Per layer: DP_LATENCY+2 cycles.
- With start sampled at edge 0, done is high in cycle 1 + NUM_LAYERS·(DP_LATENCY+2), plus 1 with ARGMAX. Defaults: cycle 13 (14 with ARGMAX).
- busy rises the cycle after start and falls the cycle after done.
- A new start is accepted earliest the cycle after done.

## Configuration
- DNN_SEQ_ARGMAX_EN defined:
  - ARG state is present and out_class is valid with done.
  - Argmax compares the 8 signed elements; ties resolve to the lowest index.
- DNN_SEQ_ARGMAX_EN undefined:
  - no ARG state; out_class is tied to 0;
  - latency is as stated without the +1.

## Structure
- Shared package dnn_pkg holds: DATA_W=16, VEC_N=8, the state enum, and the vector pack/unpack helpers.
- One sub-module, argmax8: combinational signed 8-way compare tree, instantiated only under the macro.

## Test plan
- Reset, then a single inference with NUM_LAYERS=3, DP_LATENCY=2:
  - dp_clr high in cycles 1, 5, 9; dp_en high in 2–3, 6–7, 10–11; layer_sel 0, 1, 2;
  - done in cycle 13;
  - out_vec equals the dp_a sampled in cycle 12.
- Feedback check: a dp model returning dp_x + 1 per element, in_vec all 0x0000 → out_vec all 0x0003.
- Abort asserted in cycle 6:
  - cycle 7 is IDLE with dp_clr=1, no done;
  - prior out_vec unchanged;
  - next start runs a full 13-cycle inference.
- Start held high continuously → inferences are back-to-back, with done in cycles 13, 27, 41; start during the DONE cycle is ignored.
- rst pulsed in cycle 8 → all outputs 0 the next cycle; the following start yields done 13 cycles later.
- ARGMAX build: final dp_a elements {5, -3, 9, 9, 0, 0, 0, 0} → out_class=2, done in cycle 14.
